// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, error-flag
// bit positions and the sample-tick divisor. UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int ERR_FRAME  = 0;
    localparam int ERR_PARITY = 1;
    localparam int ERR_BREAK  = 2;
    localparam int ERR_W      = 3;

    // Truncating divide; never below one so the tick generator always runs.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy output.
// Head data reads as zero while empty so nothing undefined leaks out.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;
    assign level   = count;

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Oversampling UART receiver feeding a FWFT FIFO, with sticky overrun.
// Optional even-parity checking is compiled in with UART_RX_PARITY_EN.
//
//   state     | meaning
//   ST_IDLE   | line idle, waiting for a 1->0 edge (blocked while break hold set)
//   ST_START  | timing to start-bit middle; high there means glitch
//   ST_DATA   | capturing payload bits, LSB first
//   ST_PARITY | checking the even-parity bit (only with UART_RX_PARITY_EN)
//   ST_STOP   | checking stop bits, then queueing the frame
module uart_rx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          uart_rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic [2:0]                    m_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          interrupt
);

    localparam int DIV   = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int FW    = DATA_BITS + ERR_W;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t            state;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 frm_err;
    logic                 par_err;
    logic                 par_low;
    logic                 brk_det;
    logic                 brk_hold;
    logic                 push_q;
    logic [FW-1:0]        push_word;

    logic                 tick;
    logic                 sample;
    logic                 is_brk;
    logic [ERR_W-1:0]     err_next;

    logic [FW-1:0]        head;
    logic                 fifo_full;
    logic                 pop;

    assign rx_s   = sync_q[1];
    assign tick   = (state != ST_IDLE) && (div_cnt == '0);
    assign sample = tick && (os_cnt == '0);
    assign pop    = m_valid && m_ready;

    // Break is judged at the first stop bit; later stop bits reuse that verdict.
    assign is_brk = (bit_cnt == STOP_LAST) ? ((shreg == '0) && par_low && !rx_s) : brk_det;

    always_comb begin
        err_next = '0;
        if (is_brk) begin
            err_next[ERR_BREAK] = 1'b1;
        end else begin
            err_next[ERR_PARITY] = par_err;
            err_next[ERR_FRAME]  = frm_err || !rx_s;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q    <= 2'b11;
            rx_prev   <= 1'b1;
            state     <= ST_IDLE;
            div_cnt   <= '0;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frm_err   <= 1'b0;
            par_err   <= 1'b0;
            brk_det   <= 1'b0;
            brk_hold  <= 1'b0;
            push_q    <= 1'b0;
            push_word <= '0;
`ifdef UART_RX_PARITY_EN
            par_low   <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            rx_prev <= rx_s;
            push_q  <= 1'b0;
            if (brk_hold && rx_s) begin
                brk_hold <= 1'b0;
            end
            if (state != ST_IDLE) begin
                div_cnt <= (div_cnt == '0) ? DIV_LAST : div_cnt - 1'b1;
            end
            if (tick) begin
                os_cnt <= (os_cnt == '0) ? OS_LAST : os_cnt - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s && !brk_hold) begin
                        state   <= ST_START;
                        div_cnt <= DIV_LAST;
                        os_cnt  <= OS_HALF;
                        frm_err <= 1'b0;
                        par_err <= 1'b0;
                        brk_det <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_cnt <= DATA_LAST;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == '0) begin
`ifdef UART_RX_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
                            bit_cnt <= STOP_LAST;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample) begin
                        par_err <= (rx_s != ^shreg);
                        par_low <= !rx_s;
                        state   <= ST_STOP;
                        bit_cnt <= STOP_LAST;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample) begin
                        if (bit_cnt == STOP_LAST) begin
                            brk_det <= is_brk;
                        end
                        if (!rx_s) begin
                            frm_err <= 1'b1;
                        end
                        if (bit_cnt == '0) begin
                            push_q    <= 1'b1;
                            push_word <= {err_next, shreg};
                            brk_hold  <= is_brk;
                            state     <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_low = 1'b1;
`endif

    // New drop wins over a clear in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overrun <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (push_q),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .valid     (m_valid),
        .full      (fifo_full),
        .level     (level)
    );

    assign m_data    = head[DATA_BITS-1:0];
    assign m_err     = head[FW-1:DATA_BITS];
    assign interrupt = m_valid || overrun;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param: default line timing (DIV=54, 864
// cycles per bit) with a 2-entry FIFO so the overrun case stays short.
module tb_uart_rx_fifo_param;

    localparam int BIT_CYC = 864;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // start-edge to m_valid: 2 sync + 1 edge + 8 ticks + (8 data + parity + 1 stop) bits, +1 push
    localparam int EXP_LAT = 4 + 54 * (8 + 16 * (9 + PB));

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       uart_rx;
    logic [7:0] m_data;
    logic [2:0] m_err;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] level;
    logic       overrun;
    logic       clr_overrun;
    logic       interrupt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cyc = 0;
    logic valid_seen = 1'b0;

    uart_rx_fifo_param #(
        .FIFO_DEPTH (2)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .uart_rx     (uart_rx),
        .m_data      (m_data),
        .m_err       (m_err),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .level       (level),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .interrupt   (interrupt)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (m_valid && !valid_seen) begin
            valid_seen = 1'b1;
            valid_cyc  = cyc;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge aclk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (BIT_CYC) @(negedge aclk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^d) ^ par_flip;
        repeat (BIT_CYC) @(negedge aclk);
`endif
        uart_rx = stop_val;
        repeat (BIT_CYC) @(negedge aclk);
        uart_rx = 1'b1;
        @(negedge aclk);
    endtask

    task automatic pop_one();
        @(negedge aclk);
        m_ready = 1'b1;
        @(negedge aclk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn     = 1'b0;
        uart_rx     = 1'b1;
        m_ready     = 1'b0;
        clr_overrun = 1'b0;
        repeat (4) @(negedge aclk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_interrupt: got %0b expected 0", interrupt); end
        n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        n_cmp++; if (m_err !== 3'b000) begin n_err++; $display("FAIL reset_m_err: got %0b expected 000", m_err); end
        aresetn = 1'b1;
        repeat (20) @(negedge aclk);
    endtask

    task automatic test_frame_div();
        int t0;
        valid_seen = 1'b0;
        t0 = cyc;
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (10) @(negedge aclk);
        n_cmp++; if (!valid_seen || (valid_cyc - t0) !== EXP_LAT) begin n_err++; $display("FAIL div_latency: got %0d expected %0d", valid_cyc - t0, EXP_LAT); end
        n_cmp++; if (m_data !== 8'h55) begin n_err++; $display("FAIL frame55_data: got %0h expected 55", m_data); end
        n_cmp++; if (m_err !== 3'b000) begin n_err++; $display("FAIL frame55_err: got %0b expected 000", m_err); end
        n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL frame55_level: got %0d expected 1", level); end
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL frame55_irq: got %0b expected 1", interrupt); end
        pop_one();
        n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL pop55_level: got %0d expected 0", level); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL pop55_irq: got %0b expected 0", interrupt); end
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0;
        repeat (3) @(negedge aclk);
        uart_rx = 1'b1;
        repeat (1000) @(negedge aclk);
        n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL glitch_level: got %0d expected 0", level); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %0b expected 0", m_valid); end
    endtask

    task automatic test_back_to_back_overrun();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
        end
        repeat (10) @(negedge aclk);
        n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL ovr_level: got %0d expected 2", level); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %0b expected 1", overrun); end
        n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL ovr_head: got %0h expected 00", m_data); end
        @(negedge aclk);
        clr_overrun = 1'b1;
        @(negedge aclk);
        clr_overrun = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %0b expected 0", overrun); end
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL ovr_irq_valid: got %0b expected 1", interrupt); end
        pop_one();
        n_cmp++; if (m_data !== 8'h01) begin n_err++; $display("FAIL ovr_head2: got %0h expected 01", m_data); end
        n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL ovr_level2: got %0d expected 1", level); end
        pop_one();
        n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL ovr_level3: got %0d expected 0", level); end
    endtask

    task automatic test_frame_error();
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (10) @(negedge aclk);
        n_cmp++; if (m_data !== 8'hA3) begin n_err++; $display("FAIL frerr_data: got %0h expected a3", m_data); end
        n_cmp++; if (m_err !== 3'b001) begin n_err++; $display("FAIL frerr_err: got %0b expected 001", m_err); end
        pop_one();
    endtask

    task automatic test_break();
        uart_rx = 1'b0;
        repeat (2 * (10 + PB) * BIT_CYC) @(negedge aclk);
        uart_rx = 1'b1;
        repeat (2000) @(negedge aclk);
        n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL brk_level: got %0d expected 1", level); end
        n_cmp++; if (m_err !== 3'b100) begin n_err++; $display("FAIL brk_err: got %0b expected 100", m_err); end
        n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL brk_data: got %0h expected 00", m_data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h3C;
        // entry from the break test is still queued; reset must flush it
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge aclk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = d[i];
            repeat (BIT_CYC) @(negedge aclk);
        end
        uart_rx = d[4];
        repeat (400) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL rstmid_level: got %0d expected 0", level); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0b expected 0", m_valid); end
        repeat (5) @(negedge aclk);
        aresetn = 1'b1;
        uart_rx = 1'b1;
        repeat (2000) @(negedge aclk);
        n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL rstmid_nopush: got %0d expected 0", level); end
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (10) @(negedge aclk);
        n_cmp++; if (m_data !== 8'h3C) begin n_err++; $display("FAIL after_rst_data: got %0h expected 3c", m_data); end
        n_cmp++; if (m_err !== 3'b000) begin n_err++; $display("FAIL after_rst_err: got %0b expected 000", m_err); end
        n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL after_rst_level: got %0d expected 1", level); end
        pop_one();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge aclk);
        n_cmp++; if (m_err !== 3'b010) begin n_err++; $display("FAIL par_bad: got %0b expected 010", m_err); end
        pop_one();
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (10) @(negedge aclk);
        n_cmp++; if (m_err !== 3'b000) begin n_err++; $display("FAIL par_good: got %0b expected 000", m_err); end
        pop_one();
    endtask
`endif

    initial begin
        test_reset();
        test_frame_div();
        test_glitch();
        test_back_to_back_overrun();
        test_frame_error();
        test_break();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
